// File: rtl/vertex_rom_arbiter.sv
// Two-requester round-robin arbiter in front of one shared vertex ROM read port.
// Each grant carries a {valid, id} tag down a READ_LATENCY pipeline so the returned word is steered to its owner.
module vertex_rom_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 96,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [1:0]            req_in,
    input  logic [ADDR_WIDTH-1:0] addr0_in,
    input  logic [ADDR_WIDTH-1:0] addr1_in,
    output logic [1:0]            gnt_out,
    output logic [ADDR_WIDTH-1:0] rom_addr_out,
    input  logic [DATA_WIDTH-1:0] rom_data_in,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic [1:0]            rvalid_out,
    output logic                  busy_out
);

    // Handshake: req_in[i] and addr_i are held until gnt_out[i] pulses for one cycle;
    // the request is consumed by that pulse, and dropping req_in[i] earlier withdraws it.
    logic                    ptr_q, ptr_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_id_q, tag_id_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rvalid_q, rvalid_d;
    logic [1:0]              eligible;
    logic                    win;

    always_comb begin
        eligible   = req_in & ~gnt_q;
        win        = 1'b0;
        gnt_d      = 2'b00;
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        if (eligible == 2'b11) begin
            win = ptr_q;
        end else begin
            win = eligible[1];
        end
        if (|eligible) begin
            gnt_d      = win ? 2'b10 : 2'b01;
            ptr_d      = ~win;
            rom_addr_d = win ? addr1_in : addr0_in;
        end
    end

    // Stage k holds the tag for the grant issued k+1 cycles ago; the last stage lines up with ROM data.
    always_comb begin
        tag_vld_d[0] = |gnt_q;
        tag_id_d[0]  = gnt_q[1];
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_comb begin
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        if (tag_vld_q[READ_LATENCY-1]) begin
            rdata_d  = rom_data_in;
            rvalid_d = tag_id_q[READ_LATENCY-1] ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ptr_q      <= 1'b0;
            gnt_q      <= 2'b00;
            rom_addr_q <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 2'b00;
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rom_addr_q <= rom_addr_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign gnt_out      = gnt_q;
    assign rom_addr_out = rom_addr_q;
    assign rdata_out    = rdata_q;
    assign rvalid_out   = rvalid_q;
    assign busy_out     = (|gnt_q) | (|tag_vld_q);

endmodule

// File: tb/tb_vertex_rom_arbiter.sv
// Directed and randomized bench for vertex_rom_arbiter with a 2-cycle ROM model.
// Expected grants/returns are hand-derived per scenario; the random run uses an expected-return queue.
module tb_vertex_rom_arbiter;

    localparam int AW = 16;
    localparam int DW = 96;
    localparam int RL = 2;

    logic          clk_in;
    logic          rst_in;
    logic [1:0]    req_in;
    logic [AW-1:0] addr0_in;
    logic [AW-1:0] addr1_in;
    logic [1:0]    gnt_out;
    logic [AW-1:0] rom_addr_out;
    logic [DW-1:0] rom_data_in;
    logic [DW-1:0] rdata_out;
    logic [1:0]    rvalid_out;
    logic          busy_out;

    int errors = 0;
    int checks = 0;

    logic [AW:0]   exp_q[$];
    logic [AW-1:0] addr_pipe[RL];

    vertex_rom_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .req_in      (req_in),
        .addr0_in    (addr0_in),
        .addr1_in    (addr1_in),
        .gnt_out     (gnt_out),
        .rom_addr_out(rom_addr_out),
        .rom_data_in (rom_data_in),
        .rdata_out   (rdata_out),
        .rvalid_out  (rvalid_out),
        .busy_out    (busy_out)
    );

    // Clock and reset defaults
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = a * 16'd7;
        return {a ^ 16'hA5C3, a, a + 16'h1234, ~a, m, {a[7:0], a[15:8]} ^ 16'hBEEF};
    endfunction

    // ROM model: address presented in cycle T yields data in cycle T+RL
    always @(posedge clk_in) begin
        addr_pipe[0] <= rom_addr_out;
        for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
    assign rom_data_in = rom_f(addr_pipe[RL-1]);

    // Driver tasks
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in   = 1'b0;
        req_in   = 2'b00;
        addr0_in = '0;
        addr1_in = '0;
        step();
        step();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in   = 1'b0;
        req_in   = 2'b11;
        addr0_in = 16'h1111;
        addr1_in = 16'h2222;
        step();
        step();
        checks++; if (gnt_out !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_out); end
        checks++; if (rvalid_out !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        checks++; if (rom_addr_out !== 16'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr_out); end
        checks++; if (rdata_out !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_out); end
        req_in = 2'b00;
    endtask

    task automatic test_single();
        rst_in   = 1'b1;
        req_in   = 2'b01;
        addr0_in = 16'd5;
        step();
        checks++; if (gnt_out !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", gnt_out); end
        checks++; if (rom_addr_out !== 16'd5) begin errors++; $display("FAIL single_rom_addr: got %0d want 5", rom_addr_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL single_busy_gnt: got %b want 1", busy_out); end
        req_in = 2'b00;
        for (int k = 2; k <= 5; k++) begin
            step();
            checks++; if (gnt_out !== 2'b00) begin errors++; $display("FAIL single_gnt_idle c%0d: got %b want 00", k, gnt_out); end
            checks++; if (rom_addr_out !== 16'd5) begin errors++; $display("FAIL single_addr_hold c%0d: got %0d want 5", k, rom_addr_out); end
            checks++;
            if (rvalid_out !== ((k == 4) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL single_rvalid c%0d: got %b want %b", k, rvalid_out, (k == 4) ? 2'b01 : 2'b00);
            end
            if (k >= 4) begin
                checks++; if (rdata_out !== rom_f(16'd5)) begin errors++; $display("FAIL single_rdata c%0d: got %h want %h", k, rdata_out, rom_f(16'd5)); end
            end
            checks++;
            if (busy_out !== (k <= 3)) begin errors++; $display("FAIL single_busy c%0d: got %b want %b", k, busy_out, (k <= 3)); end
        end
    endtask

    task automatic test_alternate();
        logic [1:0]    exp_g;
        logic [1:0]    exp_v;
        logic [AW-1:0] exp_a;
        do_reset();
        req_in   = 2'b11;
        addr0_in = 16'd10;
        addr1_in = 16'd20;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_g = (k > 6) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            checks++; if (gnt_out !== exp_g) begin errors++; $display("FAIL alt_gnt c%0d: got %b want %b", k, gnt_out, exp_g); end
            if (k <= 6) begin
                exp_a = (k % 2 == 1) ? 16'd10 : 16'd20;
                checks++; if (rom_addr_out !== exp_a) begin errors++; $display("FAIL alt_rom_addr c%0d: got %0d want %0d", k, rom_addr_out, exp_a); end
            end
            exp_v = (k < 4) ? 2'b00 : (((k - 3) % 2 == 1) ? 2'b01 : 2'b10);
            checks++; if (rvalid_out !== exp_v) begin errors++; $display("FAIL alt_rvalid c%0d: got %b want %b", k, rvalid_out, exp_v); end
            if (k >= 4) begin
                exp_a = ((k - 3) % 2 == 1) ? 16'd10 : 16'd20;
                checks++; if (rdata_out !== rom_f(exp_a)) begin errors++; $display("FAIL alt_rdata c%0d: got %h want %h", k, rdata_out, rom_f(exp_a)); end
            end
            checks++; if (busy_out !== (k <= 8)) begin errors++; $display("FAIL alt_busy c%0d: got %b want %b", k, busy_out, (k <= 8)); end
            if (k == 6) req_in = 2'b00;
        end
    endtask

    task automatic test_hold();
        logic [1:0] exp_g;
        logic [1:0] exp_v;
        do_reset();
        req_in   = 2'b10;
        addr1_in = 16'd7;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b00;
            checks++; if (gnt_out !== exp_g) begin errors++; $display("FAIL hold_gnt c%0d: got %b want %b", k, gnt_out, exp_g); end
            exp_v = (k >= 4 && k % 2 == 0) ? 2'b10 : 2'b00;
            checks++; if (rvalid_out !== exp_v) begin errors++; $display("FAIL hold_rvalid c%0d: got %b want %b", k, rvalid_out, exp_v); end
            if (exp_v != 2'b00) begin
                checks++; if (rdata_out !== rom_f(16'd7)) begin errors++; $display("FAIL hold_rdata c%0d: got %h want %h", k, rdata_out, rom_f(16'd7)); end
            end
        end
        req_in   = 2'b11;
        addr0_in = 16'd9;
        step();
        checks++; if (gnt_out !== 2'b01) begin errors++; $display("FAIL hold_ptr_pref0: got %b want 01", gnt_out); end
        checks++; if (rom_addr_out !== 16'd9) begin errors++; $display("FAIL hold_ptr_addr: got %0d want 9", rom_addr_out); end
        req_in = 2'b00;
    endtask

    task automatic test_drop();
        logic [1:0] exp_v;
        do_reset();
        req_in   = 2'b11;
        addr0_in = 16'd11;
        addr1_in = 16'd22;
        step();
        checks++; if (gnt_out !== 2'b01) begin errors++; $display("FAIL drop_first_gnt: got %b want 01", gnt_out); end
        req_in = 2'b00;
        for (int k = 2; k <= 7; k++) begin
            step();
            checks++; if (gnt_out !== 2'b00) begin errors++; $display("FAIL drop_gnt c%0d: got %b want 00", k, gnt_out); end
            exp_v = (k == 4) ? 2'b01 : 2'b00;
            checks++; if (rvalid_out !== exp_v) begin errors++; $display("FAIL drop_rvalid c%0d: got %b want %b", k, rvalid_out, exp_v); end
        end
        checks++; if (rdata_out !== rom_f(16'd11)) begin errors++; $display("FAIL drop_rdata: got %h want %h", rdata_out, rom_f(16'd11)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_in   = 2'b01;
        addr0_in = 16'd3;
        step();
        checks++; if (gnt_out !== 2'b01) begin errors++; $display("FAIL rmid_gnt: got %b want 01", gnt_out); end
        req_in = 2'b00;
        step();
        step();
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy_out); end
        rst_in = 1'b0;
        #1;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rmid_busy_rst: got %b want 0", busy_out); end
        checks++; if (rom_addr_out !== 16'h0) begin errors++; $display("FAIL rmid_rom_addr_rst: got %h want 0", rom_addr_out); end
        checks++; if (gnt_out !== 2'b00) begin errors++; $display("FAIL rmid_gnt_rst: got %b want 00", gnt_out); end
        step();
        checks++; if (rvalid_out !== 2'b00) begin errors++; $display("FAIL rmid_rvalid_rst: got %b want 00", rvalid_out); end
        rst_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (rvalid_out !== 2'b00) begin errors++; $display("FAIL rmid_rvalid_after c%0d: got %b want 00", k, rvalid_out); end
            checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rmid_busy_after c%0d: got %b want 0", k, busy_out); end
            checks++; if (rdata_out !== '0) begin errors++; $display("FAIL rmid_rdata_after c%0d: got %h want 0", k, rdata_out); end
        end
    endtask

    task automatic test_random();
        logic [1:0]    prev_g;
        logic [AW:0]   e;
        logic [1:0]    exp_v;
        logic [AW-1:0] a_cur;
        int            grants;
        int            returns;
        do_reset();
        exp_q.delete();
        prev_g  = 2'b00;
        grants  = 0;
        returns = 0;
        for (int cyc = 0; cyc < 10020; cyc++) begin
            step();
            checks++; if (gnt_out === 2'b11) begin errors++; $display("FAIL rnd_both_gnt c%0d: got %b", cyc, gnt_out); end
            checks++; if ((gnt_out & prev_g) !== 2'b00) begin errors++; $display("FAIL rnd_consec_gnt c%0d: got %b prev %b", cyc, gnt_out, prev_g); end
            for (int i = 0; i < 2; i++) begin
                if (gnt_out[i] === 1'b1) begin
                    a_cur = (i == 0) ? addr0_in : addr1_in;
                    checks++; if (req_in[i] !== 1'b1) begin errors++; $display("FAIL rnd_gnt_no_req c%0d: id %0d", cyc, i); end
                    checks++; if (rom_addr_out !== a_cur) begin errors++; $display("FAIL rnd_rom_addr c%0d: got %h want %h", cyc, rom_addr_out, a_cur); end
                    exp_q.push_back({1'(i), a_cur});
                    grants++;
                end
            end
            if (rvalid_out !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected_return c%0d: rvalid %b", cyc, rvalid_out);
                end else begin
                    e     = exp_q.pop_front();
                    exp_v = e[AW] ? 2'b10 : 2'b01;
                    returns++;
                    if (rvalid_out !== exp_v) begin
                        errors++; $display("FAIL rnd_rvalid c%0d: got %b want %b", cyc, rvalid_out, exp_v);
                    end
                    checks++;
                    if (rdata_out !== rom_f(e[AW-1:0])) begin
                        errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, rdata_out, rom_f(e[AW-1:0]));
                    end
                end
            end
            prev_g = gnt_out;
            for (int i = 0; i < 2; i++) begin
                if (cyc >= 10000) begin
                    req_in[i] = 1'b0;
                end else if (req_in[i] && !gnt_out[i]) begin
                    if ($urandom_range(15) == 0) req_in[i] = 1'b0;
                end else begin
                    req_in[i] = 1'($urandom_range(1));
                    if (i == 0) addr0_in = 16'($urandom_range(65535));
                    else        addr1_in = 16'($urandom_range(65535));
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_missing_returns: got %0d pending want 0", exp_q.size()); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rnd_busy_drain: got %b want 0", busy_out); end
        checks++; if (returns != grants) begin errors++; $display("FAIL rnd_return_count: got %0d want %0d", returns, grants); end
        checks++; if (grants < 1000) begin errors++; $display("FAIL rnd_grant_activity: got %0d want >=1000", grants); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_hold();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
